// File: rtl/full_adder_checker_if.sv
// Handshake and adder-facing signals of the full-adder exerciser.
// master drives start and the adder responses; slave is the exerciser itself.
interface full_adder_checker_if;
  logic       start;
  logic       C;
  logic       S;
  logic       X;
  logic       Y;
  logic       Z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  modport master (
    output start, C, S,
    input  X, Y, Z, busy, done, pass, err_count, first_fail
  );

  modport slave (
    input  start, C, S,
    output X, Y, Z, busy, done, pass, err_count, first_fail
  );
endinterface

// File: rtl/full_adder_checker.sv
// Sweeps all eight {X,Y,Z} vectors into a full adder, holds each for a settle
// time, samples C/S and records the error count and the first failing vector.
module full_adder_checker #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  full_adder_checker_if.slave bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned VEC_W = 3;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   first_q, first_d;
  logic               seen_q, seen_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               c_exp, s_exp, mismatch;

  // Reference response for the vector currently on the adder inputs.
  assign c_exp    = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
  assign s_exp    = ^vec_q;
  assign mismatch = (bus.C != c_exp) || (bus.S != s_exp);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          vec_d   = '0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
          cnt_d   = SETTLE_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + ERR_W'(1);
          if (!seen_q) begin
            first_d = vec_q;
            seen_d  = 1'b1;
          end
        end
        // Vector advances on the same edge that samples the response.
        if (vec_q == VEC_W'(7)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.X          = vec_q[2];
  assign bus.Y          = vec_q[1];
  assign bus.Z          = vec_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = first_q;
endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench for full_adder_checker with selectable faulty adder models.
module tb_full_adder_checker;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] mode;   // 0 good, 1 C stuck 0, 2 S inverted, 3 three-cycle delay

  full_adder_checker_if bif ();
  full_adder_checker_if bif1 ();

  full_adder_checker #(.SETTLE_CYCLES(4)) u_dut  (.clk(clk), .reset(reset), .bus(bif.slave));
  full_adder_checker #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bif1.slave));

  always #5 clk = ~clk;

  logic [1:0] ideal, p1, p2, p3;      // {C,S}
  logic [1:0] ideal1, q1, q2, q3;
  assign ideal  = {(bif.X & bif.Y) | (bif.X & bif.Z) | (bif.Y & bif.Z), bif.X ^ bif.Y ^ bif.Z};
  assign ideal1 = {(bif1.X & bif1.Y) | (bif1.X & bif1.Z) | (bif1.Y & bif1.Z), bif1.X ^ bif1.Y ^ bif1.Z};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= '0; p2 <= '0; p3 <= '0;
      q1 <= '0; q2 <= '0; q3 <= '0;
    end else begin
      p1 <= ideal;  p2 <= p1; p3 <= p2;
      q1 <= ideal1; q2 <= q1; q3 <= q2;
    end
  end

  always_comb begin
    case (mode)
      2'd1:    {bif.C, bif.S} = {1'b0, ideal[0]};
      2'd2:    {bif.C, bif.S} = {ideal[1], ~ideal[0]};
      2'd3:    {bif.C, bif.S} = p3;
      default: {bif.C, bif.S} = ideal;
    endcase
  end
  assign {bif1.C, bif1.S} = q3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full sweep on the SETTLE_CYCLES=4 instance; poke_edge>=0 pulses start mid-sweep.
  task automatic sweep(input string name, input logic [1:0] m, input int exp_err,
                       input int exp_first, input int exp_pass, input int poke_edge);
    mode = m;
    @(negedge clk) bif.start = 1'b1;
    @(posedge clk); #1 bif.start = 1'b0;
    check({name, " start busy"},  32'(bif.busy), 1);
    check({name, " start done"},  32'(bif.done), 0);
    check({name, " start pass"},  32'(bif.pass), 0);
    check({name, " start err"},   32'(bif.err_count), 0);
    check({name, " start first"}, 32'(bif.first_fail), 0);
    check({name, " start vec"},   32'({bif.X, bif.Y, bif.Z}), 0);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e == poke_edge - 1) bif.start = 1'b1;
      if (e == poke_edge)     bif.start = 1'b0;
      if (e % 5 == 0 && e < 40)
        check($sformatf("%s vec@%0d", name, e), 32'({bif.X, bif.Y, bif.Z}), 32'(e / 5));
      if (e == 39) check({name, " done@39"}, 32'(bif.done), 0);
    end
    check({name, " done@40"},  32'(bif.done), 1);
    check({name, " busy@40"},  32'(bif.busy), 0);
    check({name, " vec@40"},   32'({bif.X, bif.Y, bif.Z}), 7);
    check({name, " err"},      32'(bif.err_count), 32'(exp_err));
    check({name, " first"},    32'(bif.first_fail), 32'(exp_first));
    check({name, " pass"},     32'(bif.pass), 32'(exp_pass));
  endtask

  initial begin
    reset = 1'b1;
    mode = 2'd0;
    bif.start = 1'b0;
    bif1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst vec",   32'({bif.X, bif.Y, bif.Z}), 0);
    check("rst busy",  32'(bif.busy), 0);
    check("rst done",  32'(bif.done), 0);
    check("rst pass",  32'(bif.pass), 0);
    check("rst err",   32'(bif.err_count), 0);
    check("rst first", 32'(bif.first_fail), 0);
    @(negedge clk) reset = 1'b0;

    sweep("good",    2'd0, 0, 0, 1, -1);
    sweep("c_stuck", 2'd1, 4, 3, 0, -1);
    sweep("s_inv",   2'd2, 8, 0, 0, -1);
    sweep("dly_s4",  2'd3, 0, 0, 1, -1);

    // Delayed adder against the SETTLE_CYCLES=1 instance: sees the previous vector.
    begin
      int edges;
      edges = 0;
      @(negedge clk) bif1.start = 1'b1;
      @(posedge clk); #1 bif1.start = 1'b0;
      while (!bif1.done && edges < 100) begin
        @(posedge clk); #1;
        edges++;
      end
      check("dly_s1 done edge", 32'(edges), 16);
      check("dly_s1 err",   32'(bif1.err_count), 5);
      check("dly_s1 first", 32'(bif1.first_fail), 1);
      check("dly_s1 pass",  32'(bif1.pass), 0);
    end

    sweep("poke20",  2'd0, 0, 0, 1, 20);
    sweep("rep1",    2'd1, 4, 3, 0, -1);
    sweep("rep2",    2'd1, 4, 3, 0, -1);

    // Reset in the middle of a sweep with errors already counted.
    mode = 2'd2;
    @(negedge clk) bif.start = 1'b1;
    @(posedge clk); #1 bif.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre-rst err", 32'(bif.err_count), 2);
    reset = 1'b1;
    #1;
    check("mid-rst vec",  32'({bif.X, bif.Y, bif.Z}), 0);
    check("mid-rst busy", 32'(bif.busy), 0);
    check("mid-rst done", 32'(bif.done), 0);
    check("mid-rst err",  32'(bif.err_count), 0);
    @(negedge clk) reset = 1'b0;
    sweep("post_rst", 2'd0, 0, 0, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/full_adder_checker.md
# full_adder_checker

Synthesizable self-checking exerciser for the three-input full adder (inputs X, Y, Z; outputs C carry, S sum). It drives all eight input vectors onto the adder and waits a programmable settle time per vector. It then samples the adder's C/S responses, compares them against the expected majority/XOR values, and reports pass/fail, an error count and the first failing vector. It sits beside the adder instance on the board or in a system bench and replaces the hand-stepped stimulus sequence.

## Interface
- SETTLE_CYCLES, default 4: clock cycles each vector is held before sampling. Legal range 1..255.
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep. Honoured only in IDLE or DONE.
- C  in  1  carry output of the adder under test.
- S  in  1  sum output of the adder under test.
- X  out  1  adder input, vector bit 2.
- Y  out  1  adder input, vector bit 1.
- Z  out  1  adder input, vector bit 0.
- busy  out  1  sweep in progress (SETTLE or CHECK).
- done  out  1  sweep complete. Held until the next start or reset.
- pass  out  1  valid when done=1. 1 when err_count==0.
- err_count  out  4  number of mismatching vectors, 0..8.
- first_fail  out  3  vector {X,Y,Z} of the first mismatch. 0 when there are none.

## Operation
- 3-bit vector register `vec` drives {X,Y,Z} directly from a register, with no combinational path from state.
- Expected response for `vec`: C_exp = majority(X,Y,Z); S_exp = X^Y^Z.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE. On start=1:
    - clear vec, err_count, first_fail and the internal "fail seen" flag;
    - load the settle counter with SETTLE_CYCLES-1;
    - go to SETTLE.
  - SETTLE. Decrement the settle counter each cycle. At 0, go to CHECK.
  - CHECK. Sample C and S and compare them to C_exp and S_exp.
    - On mismatch: err_count += 1. If no earlier fail has been seen, first_fail <= vec and set the fail-seen flag.
    - If vec==7, go to DONE and leave vec at 7.
    - Otherwise vec <= vec+1, reload the settle counter, and go to SETTLE.
  - DONE. Hold all results. start=1 restarts exactly as from IDLE.
- A mismatch on C alone, S alone, or both counts as one error for that vector.
- err_count cannot exceed 8, so it needs no saturation.
- start while busy=1 is ignored and the sweep is unaffected.
- The settle counter is 8 bits wide.

## Timing
- Reset values: state=IDLE, X=Y=Z=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, settle counter=0.
- Reset asserted mid-sweep aborts immediately (asynchronous reset). No partial results are retained.
- Edge numbering: edge 0 is the rising edge that samples start=1. busy rises after edge 0, and X,Y,Z = 000 from edge 0.
- Each vector occupies SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE, then 1 in CHECK.
- C/S are sampled on the edge that leaves CHECK, so the adder sees a stable vector for SETTLE_CYCLES+1 cycles before sampling.
- The vector advances on the same edge that samples.
- busy falls and done rises after edge 8*(SETTLE_CYCLES+1). With the default that is edge 40.
- pass, err_count and first_fail are final when done rises.
- err_count may be observed updating incrementally while busy=1.
- A restart from DONE drops done and pass to 0 after the start edge.

## Test plan
- Correct behavioural adder, SETTLE_CYCLES=4, pulse start -> X,Y,Z step through 000..111, each held 5 cycles; done=1 at edge 40; pass=1, err_count=0, first_fail=0.
- Adder model with C stuck at 0 -> done at edge 40; err_count=4 (vectors 011, 101, 110, 111); first_fail=3'b011; pass=0.
- Adder model with S inverted -> err_count=8, first_fail=3'b000, pass=0.
- Adder model with 3-cycle output delay, SETTLE_CYCLES=1 -> errors reported, pass=0; same model with SETTLE_CYCLES=4 -> pass=1.
- Reset asserted at edge 12 of a sweep -> X=Y=Z=0, busy=0, done=0, err_count=0 immediately. Next start runs a full 40-cycle sweep.
- start pulsed at edge 20 of a running sweep -> ignored, done still at edge 40. start pulsed in DONE -> done drops after the start edge, counters clear, and the sweep repeats with identical results.
